// File: rtl/reg_rename_unit.sv
// Register rename stage: FRAT lookup, bit-vector free list, registered output, RRAT commit and one-cycle flush.
// Optional macro RENAME_FREE_BYPASS_EN lets an allocation take a tag being freed by commit in the same cycle.
module reg_rename_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int AW        = 5,
  parameter int PW        = 6
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_srcA,
  input  logic [AW-1:0] in_srcB,
  input  logic [AW-1:0] in_dst,
  input  logic          in_wr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pA,
  output logic [PW-1:0] out_pB,
  output logic [PW-1:0] out_pDst,
  output logic [PW-1:0] out_pOld,
  output logic          out_wr,
  input  logic          cm_valid,
  input  logic [AW-1:0] cm_dst,
  input  logic [PW-1:0] cm_pDst,
  input  logic [PW-1:0] cm_pOld,
  input  logic          flush,
  output logic [PW:0]   free_count
);

  logic [PW-1:0]        frat_q [ARCH_REGS];
  logic [PW-1:0]        frat_d [ARCH_REGS];
  logic [PW-1:0]        rrat_q [ARCH_REGS];
  logic [PW-1:0]        rrat_d [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_q, free_d;
  logic                 out_valid_q, out_valid_d;
  logic [PW-1:0]        out_pa_q, out_pa_d, out_pb_q, out_pb_d;
  logic [PW-1:0]        out_pdst_q, out_pdst_d, out_pold_q, out_pold_d;
  logic                 out_wr_q, out_wr_d;

  logic          alloc_needed, commit_en, tag_ok, accept;
  logic [PW-1:0] tag;
  logic [PW:0]   cnt;

  always_comb begin
    alloc_needed = in_wr && (in_dst != '0);
    commit_en    = cm_valid && (cm_dst != '0);
    // Downward scan leaves the lowest-indexed free tag selected.
    tag_ok = 1'b0;
    tag    = '0;
    for (int j = PHYS_REGS - 1; j >= 0; j--) begin
      if (free_q[j]) begin
        tag_ok = 1'b1;
        tag    = PW'(j);
      end
    end
`ifdef RENAME_FREE_BYPASS_EN
    if (!tag_ok && commit_en) begin
      tag_ok = 1'b1;
      tag    = cm_pOld;
    end
`endif
    in_ready = (!out_valid_q || out_ready) && (!alloc_needed || tag_ok) && !flush;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    frat_d      = frat_q;
    rrat_d      = rrat_q;
    free_d      = free_q;
    out_valid_d = out_valid_q;
    out_pa_d    = out_pa_q;
    out_pb_d    = out_pb_q;
    out_pdst_d  = out_pdst_q;
    out_pold_d  = out_pold_q;
    out_wr_d    = out_wr_q;

    if (commit_en) rrat_d[cm_dst] = cm_pDst;

    if (flush) begin
      // Every tag not named by the retired map is free again; tag 0 stays reserved.
      frat_d = rrat_d;
      free_d = '1;
      for (int i = 0; i < ARCH_REGS; i++) free_d[rrat_d[i]] = 1'b0;
      free_d[0]   = 1'b0;
      out_valid_d = 1'b0;
      out_pa_d    = '0;
      out_pb_d    = '0;
      out_pdst_d  = '0;
      out_pold_d  = '0;
      out_wr_d    = 1'b0;
    end else begin
      // Set before clear so a bypassed tag stays allocated.
      if (commit_en) free_d[cm_pOld] = 1'b1;
      if (accept) begin
        out_valid_d = 1'b1;
        out_pa_d    = frat_q[in_srcA];
        out_pb_d    = frat_q[in_srcB];
        out_wr_d    = alloc_needed;
        if (alloc_needed) begin
          out_pdst_d     = tag;
          out_pold_d     = frat_q[in_dst];
          frat_d[in_dst] = tag;
          free_d[tag]    = 1'b0;
        end else begin
          out_pdst_d = '0;
          out_pold_d = '0;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        out_pa_d    = '0;
        out_pb_d    = '0;
        out_pdst_d  = '0;
        out_pold_d  = '0;
        out_wr_d    = 1'b0;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int j = 0; j < PHYS_REGS; j++) cnt = cnt + (PW+1)'(free_q[j]);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        frat_q[i] <= PW'(i);
        rrat_q[i] <= PW'(i);
      end
      for (int j = 0; j < PHYS_REGS; j++) free_q[j] <= (j >= ARCH_REGS);
      out_valid_q <= 1'b0;
      out_pa_q    <= '0;
      out_pb_q    <= '0;
      out_pdst_q  <= '0;
      out_pold_q  <= '0;
      out_wr_q    <= 1'b0;
    end else begin
      frat_q      <= frat_d;
      rrat_q      <= rrat_d;
      free_q      <= free_d;
      out_valid_q <= out_valid_d;
      out_pa_q    <= out_pa_d;
      out_pb_q    <= out_pb_d;
      out_pdst_q  <= out_pdst_d;
      out_pold_q  <= out_pold_d;
      out_wr_q    <= out_wr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pA     = out_pa_q;
  assign out_pB     = out_pb_q;
  assign out_pDst   = out_pdst_q;
  assign out_pOld   = out_pold_q;
  assign out_wr     = out_wr_q;
  assign free_count = cnt;

endmodule
